sdram_host_arbiter: RTL and testbench
=====================================

// Module: sdram_host_arbiter
// PURPOSE
//  Two-port front end driving the native host port (h_*) of the simulation SDRAM controller.
//  Port A: 8-bit CPU byte bus, high priority, with a one-word read cache.
//  Port B: 16-bit word bus (ROM loader / DMA), byte-enabled.
//  Serialises both onto the single h_access/h_compl handshake; anti-starvation guard for B.
// PARAMETERS
//  CACHE_EN     1  1 = port-A one-word read cache enabled; 0 = every A read goes to SDRAM
//  B_STARVE_MAX 4  consecutive A grants while B waits before B is forced next (1..15)
// PORTS
//  clk           in   1   single clock for all logic
//  reset         in   1   synchronous, active-high reset
//  a_req         in   1   port A request, level; held until a_ack
//  a_wr          in   1   1 = write, 0 = read; stable while a_req=1
//  a_addr        in   25  byte address
//  a_wdata       in   8   write byte
//  a_rdata       out  8   read byte, valid in the a_ack cycle
//  a_ack         out  1   one-cycle completion pulse
//  b_req         in   1   port B request, level; held until b_ack
//  b_wr          in   1   1 = write, 0 = read
//  b_addr        in   24  word address [24:1]
//  b_be          in   2   byte enables [1]=hi, [0]=lo; writes only
//  b_wdata       in   16  write word
//  b_rdata       out  16  read word, valid in the b_ack cycle
//  b_ack         out  1   one-cycle completion pulse
//  h_addr        out  25  controller word address [25:1]
//  h_wdata       out  16  controller write data
//  h_rdata       in   16  controller read data, valid when h_compl=1
//  h_wr_en       out  1   controller write enable
//  h_bytesel     out  2   controller byte select
//  h_access      out  1   controller request level
//  h_compl       in   1   controller one-cycle completion
//  h_config_done in   1   controller init complete
//  busy          out  1   1 in every state except IDLE
// BEHAVIOUR
//  Registers: all outputs are registered.
//   Reset values: a_ack=b_ack=0, h_access=0, h_wr_en=0, h_bytesel=0, rdata=0, busy=1.
//   Cache invalid; starve counter=0; state=WAIT_CFG.
//  FSM transitions:
//   WAIT_CFG -> IDLE when h_config_done=1.
//   IDLE -> RESP on a cache hit.
//   IDLE -> XFER on a miss or any write.
//   XFER -> RESP when h_compl=1 is sampled.
//   RESP -> IDLE after 1 cycle.
//  Arbitration (in IDLE):
//   A wins if a_req=1, unless b_req=1 and starve==B_STARVE_MAX.
//   Each A grant while b_req=1 increments starve (saturating); a B grant clears it.
//  Port A mapping:
//   h_addr = a_addr[24:1].
//   h_bytesel = a_addr[0] ? 2'b10 : 2'b01.
//   h_wdata = {a_wdata, a_wdata}.
//   Read data = selected byte of h_rdata.
//  Port B mapping: h_addr = {1'b0, b_addr}; h_bytesel = b_wr ? b_be : 2'b11.
//   b_wr=1 with b_be=00: acked in RESP, no SDRAM access.
//  Handshake: h_access is set on the IDLE->XFER edge and cleared on the edge that samples h_compl=1.
//   h_access is never high in the cycle after h_compl. The controller needs this.
//   h_addr, h_wdata, h_wr_en and h_bytesel are stable while h_access=1.
//   A request is not re-sampled in the ack cycle. A requester may hold req for a back-to-back access.
//   That access starts no earlier than 1 cycle after the ack.
//  Latency (from the first cycle req is high in IDLE):
//   A cache hit: ack at +1.
//   SDRAM access: h_access at +1, ack 1 cycle after h_compl.
//  Cache (CACHE_EN=1):
//   Tag = word address; data = 16 bits; valid bit.
//   Filled by every completed A read.
//   Invalidated by a completed write (A or B) to the same word; writes to other words leave it alone.
//   B reads do not fill it.
//  Boundaries:
//   Simultaneous a_req/b_req: A wins unless starve==B_STARVE_MAX.
//   Reset asserted in XFER: h_access=0 on the next edge; no ack issued; cache invalidated.
//   h_config_done dropping after WAIT_CFG is ignored.
// TESTING
//  1 Reset held 3 cycles, h_config_done=0 -> h_access=0, busy=1.
//    Raise h_config_done -> busy=0 next cycle.
//  2 A read 0x000101, model returns h_rdata=0xBEEF -> h_bytesel=10, h_addr=0x80.
//    h_access drops on the h_compl edge; a_ack with a_rdata=0xBE one cycle after h_compl.
//  3 A read 0x000100 right after test 2 -> no h_access; a_ack at +1, a_rdata=0xEF.
//    B write 0x80 be=01 wdata=0x1234 -> cache invalidated.
//    Then A read 0x000100 -> h_access asserted.
//  4 a_req held continuously, b_req=1, B_STARVE_MAX=4 -> exactly 4 A grants, then 1 B grant.
//    Then A resumes.
//  5 Assert reset while h_access=1 in XFER -> h_access=0 at the next edge, no ack.
//    State is WAIT_CFG afterwards.
//  6 B write with b_be=00 -> b_ack at +1; h_access stays 0 throughout.

Source files
------------

// File: rtl/sdram_host_arbiter_if.sv
// rtl/sdram_host_arbiter_if.sv - port A/B requester buses and SDRAM controller host port
interface sdram_host_arbiter_if;
  logic        a_req;
  logic        a_wr;
  logic [24:0] a_addr;
  logic [7:0]  a_wdata;
  logic [7:0]  a_rdata;
  logic        a_ack;

  logic        b_req;
  logic        b_wr;
  logic [23:0] b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic        b_ack;

  logic [24:0] h_addr;
  logic [15:0] h_wdata;
  logic [15:0] h_rdata;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic        h_access;
  logic        h_compl;
  logic        h_config_done;

  // arbiter side
  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_rdata, a_ack,
    input  b_req, b_wr, b_addr, b_be, b_wdata,
    output b_rdata, b_ack,
    output h_addr, h_wdata, h_wr_en, h_bytesel, h_access,
    input  h_rdata, h_compl, h_config_done
  );

  // requesters plus controller side
  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_rdata, a_ack,
    output b_req, b_wr, b_addr, b_be, b_wdata,
    input  b_rdata, b_ack,
    input  h_addr, h_wdata, h_wr_en, h_bytesel, h_access,
    output h_rdata, h_compl, h_config_done
  );
endinterface

// File: rtl/sdram_host_arbiter.sv
// rtl/sdram_host_arbiter.sv - serialises CPU byte port A and word port B onto the SDRAM host port
module sdram_host_arbiter #(
  parameter int          CACHE_EN     = 1,
  parameter int unsigned B_STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_host_arbiter_if.slave  bus,
  output logic                 busy
);
  typedef enum logic [1:0] {WAIT_CFG, IDLE, XFER, RESP} state_t;

  localparam bit         USE_CACHE  = (CACHE_EN != 0);
  localparam logic [3:0] STARVE_MAX = 4'(B_STARVE_MAX);

  state_t      state, state_d;
  logic [3:0]  starve;
  logic        cache_valid;
  logic [23:0] cache_tag;
  logic [15:0] cache_data;
  logic        cur_a, cur_wr, cur_lsb;
  logic [23:0] cur_word;

  logic        grant_a, grant_b, a_hit, b_null, start_xfer;
  logic        a_ack_d, b_ack_d, busy_d;
  logic [7:0]  a_hit_byte;

  always_comb begin
    grant_a    = bus.a_req && !(bus.b_req && starve == STARVE_MAX);
    grant_b    = bus.b_req && !grant_a;
    a_hit      = USE_CACHE && !bus.a_wr && cache_valid && (cache_tag == bus.a_addr[24:1]);
    b_null     = bus.b_wr && (bus.b_be == 2'b00);
    a_hit_byte = bus.a_addr[0] ? cache_data[15:8] : cache_data[7:0];
    start_xfer = (state == IDLE) && ((grant_a && !a_hit) || (grant_b && !b_null));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_CFG;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      WAIT_CFG: if (bus.h_config_done) state_d = IDLE;
      IDLE: begin
        if (grant_a)      state_d = a_hit ? RESP : XFER;
        else if (grant_b) state_d = b_null ? RESP : XFER;
      end
      XFER:     if (bus.h_compl) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = WAIT_CFG;
    endcase
  end

  // Next values of the registered outputs; acks fire on entry to RESP.
  always_comb begin
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    if (state == IDLE) begin
      a_ack_d = grant_a && a_hit;
      b_ack_d = grant_b && b_null;
    end else if (state == XFER && bus.h_compl) begin
      a_ack_d = cur_a;
      b_ack_d = !cur_a;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.a_ack     <= 1'b0;
      bus.b_ack     <= 1'b0;
      bus.a_rdata   <= '0;
      bus.b_rdata   <= '0;
      bus.h_access  <= 1'b0;
      bus.h_wr_en   <= 1'b0;
      bus.h_bytesel <= '0;
      bus.h_addr    <= '0;
      bus.h_wdata   <= '0;
      busy          <= 1'b1;
      starve        <= '0;
      cache_valid   <= 1'b0;
      cache_tag     <= '0;
      cache_data    <= '0;
      cur_a         <= 1'b0;
      cur_wr        <= 1'b0;
      cur_lsb       <= 1'b0;
      cur_word      <= '0;
    end else begin
      bus.a_ack <= a_ack_d;
      bus.b_ack <= b_ack_d;
      busy      <= busy_d;

      if (state == IDLE) begin
        if (grant_a && bus.b_req && starve != 4'hF) starve <= starve + 4'd1;
        if (grant_b) starve <= '0;
        if (grant_a && a_hit) bus.a_rdata <= a_hit_byte;
      end

      // Command fields are latched once here and held for the whole access.
      if (start_xfer) begin
        bus.h_access <= 1'b1;
        cur_a        <= grant_a;
        cur_lsb      <= bus.a_addr[0];
        if (grant_a) begin
          cur_wr        <= bus.a_wr;
          cur_word      <= bus.a_addr[24:1];
          bus.h_addr    <= {1'b0, bus.a_addr[24:1]};
          bus.h_wdata   <= {2{bus.a_wdata}};
          bus.h_wr_en   <= bus.a_wr;
          bus.h_bytesel <= bus.a_addr[0] ? 2'b10 : 2'b01;
        end else begin
          cur_wr        <= bus.b_wr;
          cur_word      <= bus.b_addr;
          bus.h_addr    <= {1'b0, bus.b_addr};
          bus.h_wdata   <= bus.b_wdata;
          bus.h_wr_en   <= bus.b_wr;
          bus.h_bytesel <= bus.b_wr ? bus.b_be : 2'b11;
        end
      end

      if (state == XFER && bus.h_compl) begin
        bus.h_access <= 1'b0;
        bus.h_wr_en  <= 1'b0;
        if (cur_a && !cur_wr) bus.a_rdata <= cur_lsb ? bus.h_rdata[15:8] : bus.h_rdata[7:0];
        if (!cur_a && !cur_wr) bus.b_rdata <= bus.h_rdata;
        if (USE_CACHE && cur_a && !cur_wr) begin
          cache_valid <= 1'b1;
          cache_tag   <= cur_word;
          cache_data  <= bus.h_rdata;
        end else if (cur_wr && cache_tag == cur_word) begin
          cache_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb/tb_sdram_host_arbiter.sv - randomized self-checking bench for sdram_host_arbiter
module tb_sdram_host_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  sdram_host_arbiter_if bus();

  sdram_host_arbiter #(.CACHE_EN(1), .B_STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller stand-in: random completion latency, small word memory.
  logic [15:0] mem [16];
  bit          mem_init = 0;
  bit          hold_compl = 0;
  int          wait_cnt = 0;
  int          lat = 1;

  always @(posedge clk) begin
    #2;
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'(16'hBEEF + 16'(i) * 16'h1357);
      mem_init = 1;
    end
    if (reset) begin
      bus.h_compl = 1'b0;
      wait_cnt    = 0;
    end else if (bus.h_compl) begin
      bus.h_compl = 1'b0;
    end else if (bus.h_access && !hold_compl) begin
      if (wait_cnt >= lat) begin
        bus.h_rdata = mem[bus.h_addr[3:0]];
        if (bus.h_wr_en && bus.h_bytesel[0]) mem[bus.h_addr[3:0]][7:0]  = bus.h_wdata[7:0];
        if (bus.h_wr_en && bus.h_bytesel[1]) mem[bus.h_addr[3:0]][15:8] = bus.h_wdata[15:8];
        bus.h_compl = 1'b1;
        wait_cnt    = 0;
        lat         = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
  end

  // Transaction-level reference: memory image, cached word, starvation count.
  logic [15:0] ref_mem [16];
  bit          c_valid = 0;
  logic [23:0] c_tag = '0;
  int          starve_m = 0;

  bit          a_pend = 0, b_pend = 0;
  bit          t_a_wr, t_b_wr;
  logic [24:0] t_a_addr;
  logic [7:0]  t_a_wd;
  logic [23:0] t_b_addr;
  logic [1:0]  t_b_be;
  logic [15:0] t_b_wd;
  bit          from_ack = 0;

  // Observations of the last step, taken from the DUT.
  int          last_rises;
  bit          last_a_ack;
  logic [24:0] rec_addr;
  logic [1:0]  rec_sel;

  task automatic issue_a(input bit wr, input logic [24:0] addr, input logic [7:0] wd);
    t_a_wr = wr; t_a_addr = addr; t_a_wd = wd; a_pend = 1;
    bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = wd; bus.a_req = 1'b1;
  endtask

  task automatic issue_b(input bit wr, input logic [23:0] addr, input logic [1:0] be, input logic [15:0] wd);
    t_b_wr = wr; t_b_addr = addr; t_b_be = be; t_b_wd = wd; b_pend = 1;
    bus.b_wr = wr; bus.b_addr = addr; bus.b_be = be; bus.b_wdata = wd; bus.b_req = 1'b1;
  endtask

  task automatic step();
    bit          exp_a, exp_acc, got, acc_after, prev_acc, prev_compl, e_wr, s_wr;
    int          n, n0, first_acc, rises, last_compl;
    logic [23:0] word;
    logic [24:0] e_addr, s_addr;
    logic [1:0]  e_sel, s_sel;
    logic [15:0] e_wd, s_wd, cur;
    exp_a = a_pend && !(b_pend && starve_m == STARVE_MAX);
    if (exp_a) begin
      word    = t_a_addr[24:1];
      e_wr    = t_a_wr;
      e_sel   = t_a_addr[0] ? 2'b10 : 2'b01;
      e_wd    = {t_a_wd, t_a_wd};
      exp_acc = t_a_wr || !(c_valid && c_tag == word);
    end else begin
      word    = t_b_addr;
      e_wr    = t_b_wr;
      e_sel   = t_b_wr ? t_b_be : 2'b11;
      e_wd    = t_b_wd;
      exp_acc = !(t_b_wr && t_b_be == 2'b00);
    end
    e_addr = {1'b0, word};
    n0 = from_ack ? 2 : 1;
    got = 0; first_acc = -1; rises = 0; prev_acc = 0; prev_compl = 0; acc_after = 0; last_compl = -100;
    s_addr = '0; s_sel = '0; s_wd = '0; s_wr = 0;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (prev_compl && bus.h_access) acc_after = 1;
      if (bus.h_access && !prev_acc) begin
        rises++;
        if (first_acc < 0) begin
          first_acc = n; s_addr = bus.h_addr; s_sel = bus.h_bytesel; s_wd = bus.h_wdata; s_wr = bus.h_wr_en;
        end
      end
      if (bus.h_compl) begin
        last_compl = n;
        check("cmd_stable", 32'({bus.h_addr, bus.h_bytesel, bus.h_wr_en}), 32'({s_addr, s_sel, s_wr}));
        check("wdata_stable", 32'(bus.h_wdata), 32'(s_wd));
      end
      prev_acc = bus.h_access;
      prev_compl = bus.h_compl;
      if (bus.a_ack || bus.b_ack) begin
        got = 1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'(1));
    last_rises = rises;
    last_a_ack = got && bus.a_ack;
    rec_addr = s_addr;
    rec_sel = s_sel;
    if (got) begin
      cur = ref_mem[word[3:0]];
      check("ack_port_a", 32'(bus.a_ack), 32'(exp_a));
      check("ack_port_b", 32'(bus.b_ack), 32'(!exp_a));
      check("sdram_access", 32'(rises), 32'(exp_acc));
      check("access_after_compl", 32'(acc_after), 32'(0));
      if (exp_acc) begin
        check("access_latency", 32'(first_acc), 32'(n0));
        check("ack_after_compl", 32'(n - last_compl), 32'(1));
        check("h_addr", 32'(s_addr), 32'(e_addr));
        check("h_bytesel", 32'(s_sel), 32'(e_sel));
        check("h_wr_en", 32'(s_wr), 32'(e_wr));
        if (e_wr) check("h_wdata", 32'(s_wd), 32'(e_wd));
      end else begin
        check("ack_latency", 32'(n), 32'(n0));
      end
      if (exp_a && !t_a_wr) check("a_rdata", 32'(bus.a_rdata), 32'(t_a_addr[0] ? cur[15:8] : cur[7:0]));
      if (!exp_a && !t_b_wr) check("b_rdata", 32'(bus.b_rdata), 32'(cur));
    end
    if (exp_a) begin
      if (b_pend) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
      if (t_a_wr) begin
        if (t_a_addr[0]) ref_mem[word[3:0]][15:8] = t_a_wd;
        else             ref_mem[word[3:0]][7:0]  = t_a_wd;
        if (c_tag == word) c_valid = 0;
      end else begin
        c_valid = 1;
        c_tag = word;
      end
      a_pend = 0;
      bus.a_req = 1'b0;
    end else begin
      starve_m = 0;
      if (t_b_wr && t_b_be != 2'b00) begin
        if (t_b_be[0]) ref_mem[word[3:0]][7:0]  = t_b_wd[7:0];
        if (t_b_be[1]) ref_mem[word[3:0]][15:8] = t_b_wd[15:8];
        if (c_tag == word) c_valid = 0;
      end
      b_pend = 0;
      bus.b_req = 1'b0;
    end
    from_ack = 1;
  endtask

  initial begin
    reset = 1'b1;
    bus.h_config_done = 1'b0;
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_be = '0; bus.b_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'(16'hBEEF + 16'(i) * 16'h1357);

    // Reset and configuration wait
    repeat (3) @(negedge clk);
    check("rst_h_access", 32'(bus.h_access), 32'(0));
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_acks", 32'({bus.a_ack, bus.b_ack}), 32'(0));
    check("rst_h_wr_en_sel", 32'({bus.h_wr_en, bus.h_bytesel}), 32'(0));
    check("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_cfg_busy", 32'(busy), 32'(1));
    bus.h_config_done = 1'b1;
    @(negedge clk);
    check("cfg_busy", 32'(busy), 32'(0));
    from_ack = 0;

    // Odd-byte A read through SDRAM
    issue_a(1'b0, 25'h000101, 8'h00);
    step();
    check("t2_h_addr", 32'(rec_addr), 32'h80);
    check("t2_h_bytesel", 32'(rec_sel), 32'h2);
    check("t2_a_rdata", 32'(bus.a_rdata), 32'hBE);

    // Cache hit, invalidation by B, then miss
    issue_a(1'b0, 25'h000100, 8'h00);
    step();
    check("t3_hit_no_access", 32'(last_rises), 32'(0));
    check("t3_hit_rdata", 32'(bus.a_rdata), 32'hEF);
    issue_b(1'b1, 24'h000080, 2'b01, 16'h1234);
    step();
    issue_a(1'b0, 25'h000100, 8'h00);
    step();
    check("t3_miss_access", 32'(last_rises), 32'(1));
    check("t3_miss_rdata", 32'(bus.a_rdata), 32'h34);

    // B write with no byte enables
    issue_b(1'b1, 24'h000005, 2'b00, 16'hFFFF);
    step();
    check("t6_no_access", 32'(last_rises), 32'(0));

    // Reset while an access is outstanding
    hold_compl = 1;
    issue_a(1'b1, 25'h000040, 8'h55);
    for (int i = 0; i < 10 && !bus.h_access; i++) @(negedge clk);
    check("t5_access_up", 32'(bus.h_access), 32'(1));
    reset = 1'b1;
    bus.h_config_done = 1'b0;
    @(negedge clk);
    check("t5_access_drop", 32'(bus.h_access), 32'(0));
    check("t5_no_ack", 32'(bus.a_ack), 32'(0));
    bus.a_req = 1'b0;
    a_pend = 0;
    repeat (2) @(negedge clk);
    check("t5_no_ack_later", 32'(bus.a_ack), 32'(0));
    reset = 1'b0;
    hold_compl = 0;
    c_valid = 0;
    starve_m = 0;
    repeat (3) @(negedge clk);
    check("t5_wait_cfg_busy", 32'(busy), 32'(1));
    check("t5_wait_cfg_idle_bus", 32'({bus.h_access, bus.a_ack}), 32'(0));
    bus.h_config_done = 1'b1;
    @(negedge clk);
    check("t5_cfg_busy", 32'(busy), 32'(0));
    from_ack = 0;
    issue_a(1'b0, 25'h000100, 8'h00);
    step();
    check("t5_cache_cleared", 32'(last_rises), 32'(1));

    // Starvation guard: four A grants, then B, then A again
    issue_b(1'b0, 24'h000003, 2'b00, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      if (!a_pend) issue_a(1'b1, 25'(k * 2), 8'(k));
      step();
      check("t4_grant_a", 32'(last_a_ack), 32'((k == 4) ? 0 : 1));
    end

    // Random traffic; config_done dropped and must be ignored
    bus.h_config_done = 1'b0;
    for (int s = 0; s < 400; s++) begin
      if (!a_pend && $urandom_range(0, 3) != 0)
        issue_a($urandom_range(0, 2) == 0, 25'($urandom_range(0, 31)), 8'($urandom));
      if (!b_pend && $urandom_range(0, 1) != 0)
        issue_b($urandom_range(0, 1) == 1, 24'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom));
      if (!a_pend && !b_pend)
        issue_a(1'b0, 25'($urandom_range(0, 31)), 8'h00);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
